// File: rtl/ttl_scan_select_counter.sv
// Shared select register for ttl_74153_scan: manual load or wrap-around scan count.
// TTL74153_SCAN_HOLD_EN adds an active-low Hold_bar that freezes the count.
module ttl_scan_select_counter #(
  parameter int WIDTH_IN     = 4,
  parameter int WIDTH_SELECT = $clog2(WIDTH_IN)
) (
  input  logic                    Clk,
  input  logic                    Clear_bar,
`ifdef TTL74153_SCAN_HOLD_EN
  input  logic                    Hold_bar,
`endif
  input  logic                    Scan,
  input  logic [WIDTH_SELECT-1:0] Select,
  output logic [WIDTH_SELECT-1:0] sel_q,
  output logic                    wrap_q
);
  localparam int LAST = WIDTH_IN - 1;

  logic [WIDTH_SELECT-1:0] sel_d;
  logic                    wrap_d;
  logic                    upd;

`ifdef TTL74153_SCAN_HOLD_EN
  assign upd = Hold_bar;
`else
  assign upd = 1'b1;
`endif

  // Out-of-range counts (non-power-of-two WIDTH_IN) also wrap to 0.
  always_comb begin
    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (upd) begin
      if (!Scan) begin
        sel_d = Select;
      end else if (32'(sel_q) >= 32'(LAST)) begin
        sel_d  = '0;
        wrap_d = 1'b1;
      end else begin
        sel_d = sel_q + WIDTH_SELECT'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      sel_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      wrap_q <= wrap_d;
    end
  end
endmodule

// File: rtl/ttl_74153_scan.sv
// Clocked BLOCKS x WIDTH_IN-to-1 mux with shared manual/scan select register.
// TTL74153_SCAN_HOLD_EN adds Hold_bar (freezes select and Y).
`ifndef ASSIGN_UNPACK_ARRAY
`define ASSIGN_UNPACK_ARRAY(PK_LEN, PK_WIDTH, UNPK_DEST, PK_SRC) \
  for (genvar unpk_idx = 0; unpk_idx < (PK_LEN); unpk_idx++) begin : gen_unpack \
    assign UNPK_DEST[unpk_idx] = PK_SRC[((PK_WIDTH)*unpk_idx) +: PK_WIDTH]; \
  end
`endif

module ttl_74153_scan #(
  parameter int BLOCKS       = 2,
  parameter int WIDTH_IN     = 4,
  parameter int WIDTH_SELECT = $clog2(WIDTH_IN),
  parameter int DELAY_RISE   = 0,
  parameter int DELAY_FALL   = 0
) (
  input  logic                       Clk,
  input  logic                       Clear_bar,
`ifdef TTL74153_SCAN_HOLD_EN
  input  logic                       Hold_bar,
`endif
  input  logic [BLOCKS-1:0]          Enable_bar,
  input  logic                       Scan,
  input  logic [WIDTH_SELECT-1:0]    Select,
  input  logic [BLOCKS*WIDTH_IN-1:0] A_2D,
  output logic [BLOCKS-1:0]          Y,
  output logic [WIDTH_SELECT-1:0]    Select_out,
  output logic                       Wrap
);
  logic [WIDTH_IN-1:0]     a_arr [BLOCKS];
  logic [WIDTH_SELECT-1:0] sel_q;
  logic                    wrap_q;
  logic [BLOCKS-1:0]       y_q;
  logic                    sel_ok;
  logic                    upd;

  `ASSIGN_UNPACK_ARRAY(BLOCKS, WIDTH_IN, a_arr, A_2D)

  ttl_scan_select_counter #(
    .WIDTH_IN    (WIDTH_IN),
    .WIDTH_SELECT(WIDTH_SELECT)
  ) u_cnt (
    .Clk      (Clk),
    .Clear_bar(Clear_bar),
`ifdef TTL74153_SCAN_HOLD_EN
    .Hold_bar (Hold_bar),
`endif
    .Scan     (Scan),
    .Select   (Select),
    .sel_q    (sel_q),
    .wrap_q   (wrap_q)
  );

`ifdef TTL74153_SCAN_HOLD_EN
  assign upd = Hold_bar;
`else
  assign upd = 1'b1;
`endif

  assign sel_ok = 32'(sel_q) < 32'(WIDTH_IN);

  // Each block samples its input at the pre-edge select value.
  for (genvar i = 0; i < BLOCKS; i++) begin : gen_blk
    always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar)
        y_q[i] <= 1'b0;
      else if (upd)
        y_q[i] <= !Enable_bar[i] && sel_ok && a_arr[i][sel_q];
    end
  end

  if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : gen_nodly
    assign Y          = y_q;
    assign Select_out = sel_q;
    assign Wrap       = wrap_q;
  end else begin : gen_dly
    assign #(DELAY_RISE, DELAY_FALL) Y          = y_q;
    assign #(DELAY_RISE, DELAY_FALL) Select_out = sel_q;
    assign #(DELAY_RISE, DELAY_FALL) Wrap       = wrap_q;
  end
endmodule

// File: tb/tb_ttl_74153_scan.sv
// Directed bench for ttl_74153_scan: WIDTH_IN=4 and WIDTH_IN=3 instances side by side.
module tb_ttl_74153_scan;
  logic       Clk = 1'b0;
  logic       Clear_bar;
  logic       Hold_bar;
  logic [1:0] Enable_bar;
  logic       Scan, Scan3;
  logic [1:0] Select, Select3;
  logic [7:0] A_2D;
  logic [5:0] A3_2D;
  logic [1:0] Y, Y3;
  logic [1:0] Select_out, Select_out3;
  logic       Wrap, Wrap3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  ttl_74153_scan #(.BLOCKS(2), .WIDTH_IN(4)) u_dut (
    .Clk(Clk), .Clear_bar(Clear_bar),
`ifdef TTL74153_SCAN_HOLD_EN
    .Hold_bar(Hold_bar),
`endif
    .Enable_bar(Enable_bar), .Scan(Scan), .Select(Select), .A_2D(A_2D),
    .Y(Y), .Select_out(Select_out), .Wrap(Wrap)
  );

  ttl_74153_scan #(.BLOCKS(2), .WIDTH_IN(3)) u_dut3 (
    .Clk(Clk), .Clear_bar(Clear_bar),
`ifdef TTL74153_SCAN_HOLD_EN
    .Hold_bar(1'b1),
`endif
    .Enable_bar(2'b00), .Scan(Scan3), .Select(Select3), .A_2D(A3_2D),
    .Y(Y3), .Select_out(Select_out3), .Wrap(Wrap3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // dut4: block0=0100, block1=1011 -> Y by select {2,2,1,2}
  int sel4 [4] = '{1, 2, 3, 0};
  int y4   [4] = '{2, 2, 1, 2};
  int yen  [4] = '{0, 0, 1, 0};
  // dut3: block0=101, block1=010, starting from out-of-range sel 3
  int sel3 [4] = '{0, 1, 2, 0};
  int wr3  [4] = '{1, 0, 0, 1};
  int y3   [4] = '{0, 1, 2, 1};

  initial begin
    Clear_bar = 1'b0; Hold_bar = 1'b1; Enable_bar = 2'b00;
    Scan = 1'b0; Select = 2'd2; A_2D = {4'b1011, 4'b0100};
    Scan3 = 1'b0; Select3 = 2'd3; A3_2D = {3'b010, 3'b101};
    #2;
    chk("rst_y", Y, 0); chk("rst_sel", Select_out, 0); chk("rst_wrap", Wrap, 0);
    Clear_bar = 1'b1;

    tick();
    chk("man_sel", Select_out, 2); chk("man_y1", Y, 2);
    chk("w3_sel", Select_out3, 3); chk("w3_y1", Y3, 1);
    tick();
    chk("man_y2", Y, 1);
    chk("w3_oor_y", Y3, 0); chk("w3_oor_sel", Select_out3, 3);
    Select = 2'd0;
    tick();
    chk("man_sel0", Select_out, 0);

    Scan = 1'b1; Scan3 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("scan_sel%0d", k), Select_out, sel4[k % 4]);
      chk($sformatf("scan_y%0d", k), Y, y4[k % 4]);
      chk($sformatf("scan_wrap%0d", k), Wrap, (k % 4 == 3) ? 1 : 0);
      if (k < 4) begin
        chk($sformatf("w3_sel%0d", k), Select_out3, sel3[k]);
        chk($sformatf("w3_wrap%0d", k), Wrap3, wr3[k]);
        chk($sformatf("w3_y%0d", k), Y3, y3[k]);
      end
    end

    Enable_bar = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("en_sel%0d", k), Select_out, sel4[k]);
      chk($sformatf("en_y%0d", k), Y, yen[k]);
      chk($sformatf("en_wrap%0d", k), Wrap, (k == 3) ? 1 : 0);
    end
    Enable_bar = 2'b00;

    for (int k = 0; k < 3; k++) tick();
    chk("pre_rst_sel", Select_out, 3); chk("pre_rst_y", Y, 1);
    #2 Clear_bar = 1'b0;
    #1;
    chk("arst_y", Y, 0); chk("arst_sel", Select_out, 0); chk("arst_wrap", Wrap, 0);
    #1 Clear_bar = 1'b1;
    tick();
    chk("post_rst_sel", Select_out, 1); chk("post_rst_y", Y, 2);

    Scan = 1'b0; Select = 2'd3;
    tick();
    chk("mode10_sel", Select_out, 3); chk("mode10_wrap", Wrap, 0);

`ifdef TTL74153_SCAN_HOLD_EN
    Scan = 1'b1;
    tick();
    chk("hold_pre_wrap", Wrap, 1);
    tick();
    chk("hold_pre_sel", Select_out, 1); chk("hold_pre_y", Y, 2);
    Hold_bar = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold_sel%0d", k), Select_out, 1);
      chk($sformatf("hold_y%0d", k), Y, 2);
      chk($sformatf("hold_wrap%0d", k), Wrap, 0);
    end
    Hold_bar = 1'b1;
    tick(); chk("rel_sel0", Select_out, 2); chk("rel_wrap0", Wrap, 0);
    tick(); chk("rel_sel1", Select_out, 3); chk("rel_y1", Y, 1);
    tick(); chk("rel_sel2", Select_out, 0); chk("rel_wrap2", Wrap, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ttl_74153_scan.md
Name: ttl_74153_scan

Overview:
- Parametrised, clocked successor to the dual 4-input multiplexer: BLOCKS independent WIDTH_IN-to-1 selectors sharing one select register.
- Select either loaded from the Select input (manual mode) or advanced by an internal wrap-around counter (scan mode), so one part serialises parallel inputs.
- Outputs are registered.
- Sits beside the combinational mux/counter parts as a ready-made parallel-to-serial scanner.

Parameters:
- BLOCKS, 2, number of independent multiplexer blocks.
- WIDTH_IN, 4, data inputs per block; any value >= 2, not required to be a power of two.
- WIDTH_SELECT, $clog2(WIDTH_IN), width of the select path.
- DELAY_RISE, 0, rise delay applied to every output.
- DELAY_FALL, 0, fall delay applied to every output.

Ports:
- Clk  input  1  rising-edge clock; single clock domain.
- Clear_bar  input  1  asynchronous active-low reset.
- Enable_bar  input  BLOCKS  per-block active-low output enable.
- Scan  input  1  1 = auto-scan mode, 0 = manual select.
- Select  input  WIDTH_SELECT  select value used in manual mode.
- A_2D  input  BLOCKS*WIDTH_IN  data; block i occupies bits [i*WIDTH_IN +: WIDTH_IN].
- Y  output  BLOCKS  registered selected data.
- Select_out  output  WIDTH_SELECT  current select register value.
- Wrap  output  1  registered one-cycle pulse on scan wrap-around.

Behaviour:
- Interface: one clock, Clk; reset is asynchronous and active-low, Clear_bar.
- Reset (Clear_bar=0, no clock needed):
  - sel_q=0, Y=0, Wrap=0.
  - Held while low; first active edge after release acts normally.
  - Reset mid-scan abandons the sequence; scanning restarts from 0.
- Every rising Clk with Clear_bar=1:
  - Y[i] <= Enable_bar[i] ? 0 : A[i][sel_q], using the pre-edge sel_q.
  - Y[i] <= 0 if sel_q >= WIDTH_IN.
  - Scan=0: sel_q <= Select; Wrap <= 0.
  - Scan=1: if sel_q >= WIDTH_IN-1, then sel_q <= 0 and Wrap <= 1; else sel_q <= sel_q+1 and Wrap <= 0.
- Latency:
  - A -> Y: 1 edge.
  - Select -> Select_out: 1 edge.
  - Select -> Y: 2 edges.
- Out-of-range select: Select >= WIDTH_IN (non-power-of-two WIDTH_IN) loads normally but yields Y=0. In scan mode an out-of-range sel_q wraps to 0 with a Wrap pulse.
- Mode changes:
  - Scan 1->0: Select is loaded on that same edge.
  - Scan 0->1: counting continues from the current sel_q; no implicit restart.
- Enable_bar gates only Y; the counter and Wrap run regardless of enables.
- Select_out = sel_q.
- Y, Select_out and Wrap are driven through #(DELAY_RISE, DELAY_FALL).

Optional Feature:
- Macro TTL74153_SCAN_HOLD_EN.
- Defined:
  - Adds input Hold_bar (1 bit, active-low).
  - Hold_bar=0 at an edge: sel_q and Y keep their values; Wrap <= 0.
  - Clear_bar still overrides asynchronously.
  - Hold_bar=1: normal behaviour.
- Undefined: no Hold_bar port; registers update on every edge.

Decomposition:
- No package. Use the shared header's ASSIGN_UNPACK_ARRAY macro to unpack A_2D.
- Next-select/wrap logic uses a localparam LAST = WIDTH_IN-1.
- One natural sub-module: ttl_scan_select_counter.
  - Holds sel_q and Wrap; inputs Clk, Clear_bar, Scan, Select, optional Hold_bar.
  - The top instantiates it once and builds the per-block registered output selection.

Test Plan:
- Async reset: run scan to Select_out=3, pulse Clear_bar=0 between edges -> Y=00, Select_out=0, Wrap=0 immediately, no clock edge.
- Manual select, BLOCKS=2, WIDTH_IN=4: A block0=4'b0100, block1=4'b1011, Enable_bar=00, Scan=0, Select=2 -> edge1 Select_out=2; edge2 Y=2'b01.
- Scan from sel 0, 8 edges, Scan=1 -> Select_out 1,2,3,0,1,2,3,0; Wrap=1 only after edges 4 and 8; Y tracks A[i][pre-edge select] each cycle.
- Enable: Enable_bar=2'b10 during scan -> Y[1]=0 throughout; Y[0] follows block0; Select_out/Wrap sequence identical to the enabled run.
- WIDTH_IN=3 instance: manual Select=3 -> Select_out=3, Y=0 next edge; then Scan=1 -> 0 (Wrap=1), 1, 2, 0 (Wrap=1).
- With TTL74153_SCAN_HOLD_EN, scanning at Select_out=1: Hold_bar=0 for 3 edges -> Select_out=1, Y frozen, Wrap=0; release -> 2, 3, 0 with Wrap pulse.
